// File: rtl/infer_sched.sv
// Inference scheduler: accepts one feature frame, sequences the encoder / lambda /
// activation stages with fixed per-stage latencies, then holds the result until consumed.
module infer_sched #(
  parameter int unsigned BITSIZE = 24,
  parameter int unsigned L1_LAT  = 4,
  parameter int unsigned L2_LAT  = 4,
  parameter int unsigned LAM_LAT = 6,
  parameter int unsigned L3_LAT  = 4,
  parameter int unsigned L4_LAT  = 4,
  parameter int unsigned ACT_LAT = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITSIZE*10-1:0]   x_in,
  output logic [BITSIZE*10-1:0]   x_out,
  output logic                    enc1_start,
  output logic                    enc2_start,
  output logic                    enc3_start,
  output logic                    enc4_start,
  input  logic                    abort,
  input  logic [BITSIZE*2-1:0]    y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITSIZE*2-1:0]    y_out,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_L1  = 3'd1,
    S_L2  = 3'd2,
    S_LAM = 3'd3,
    S_L3  = 3'd4,
    S_L4  = 3'd5,
    S_ACT = 3'd6,
    DONE  = 3'd7
  } state_e;

  // Counter load value: a stage of N cycles loads N-1; a latency of 0 behaves as 1.
  function automatic logic [7:0] lat_ld(int unsigned lat);
    if (lat == 0) return 8'd0;
    return 8'(lat - 1);
  endfunction

  localparam logic [7:0] L1Ld  = lat_ld(L1_LAT);
  localparam logic [7:0] L2Ld  = lat_ld(L2_LAT);
  localparam logic [7:0] LamLd = lat_ld(LAM_LAT);
  localparam logic [7:0] L3Ld  = lat_ld(L3_LAT);
  localparam logic [7:0] L4Ld  = lat_ld(L4_LAT);
  localparam logic [7:0] ActLd = lat_ld(ACT_LAT);

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic [BITSIZE*10-1:0]   x_q;
  logic [BITSIZE*2-1:0]    y_q;
  logic [15:0]             frame_cnt_q;
  logic                    enc1_q, enc2_q, enc3_q, enc4_q;
  logic                    out_valid_q;

  // FSM, stage timer, data capture and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      enc1_q      <= 1'b0;
      enc2_q      <= 1'b0;
      enc3_q      <= 1'b0;
      enc4_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // Start pulses last one cycle unless re-armed below.
      enc1_q <= 1'b0;
      enc2_q <= 1'b0;
      enc3_q <= 1'b0;
      enc4_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= x_in;
            state_q <= S_L1;
            cnt_q   <= L1Ld;
            enc1_q  <= 1'b1;
          end
        end
        DONE: begin
          // abort is deliberately ignored here; completion only waits on out_ready.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: begin
          if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            case (state_q)
              S_L1: begin
                state_q <= S_L2;
                cnt_q   <= L2Ld;
                enc2_q  <= 1'b1;
              end
              S_L2: begin
                state_q <= S_LAM;
                cnt_q   <= LamLd;
              end
              S_LAM: begin
                state_q <= S_L3;
                cnt_q   <= L3Ld;
                enc3_q  <= 1'b1;
              end
              S_L3: begin
                state_q <= S_L4;
                cnt_q   <= L4Ld;
                enc4_q  <= 1'b1;
              end
              S_L4: begin
                state_q <= S_ACT;
                cnt_q   <= ActLd;
              end
              S_ACT: begin
                state_q     <= DONE;
                cnt_q       <= '0;
                y_q         <= y_in;
                out_valid_q <= 1'b1;
              end
              default: begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign frame_cnt  = frame_cnt_q;
  assign enc1_start = enc1_q;
  assign enc2_start = enc2_q;
  assign enc3_start = enc3_q;
  assign enc4_start = enc4_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_infer_sched.sv
// Bench for infer_sched: directed scenarios followed by random traffic, every cycle
// compared against a frame-level model (cycles since accept vs. cumulative stage offsets).
module tb_infer_sched;

  localparam int BS = 24;
  localparam int XW = BS * 10;
  localparam int YW = BS * 2;

  // Stage boundaries relative to the accept edge, from the default latencies.
  localparam int O2   = 4;
  localparam int OLAM = O2 + 4;
  localparam int O3   = OLAM + 6;
  localparam int O4   = O3 + 4;
  localparam int OACT = O4 + 4;
  localparam int ODN  = OACT + 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, abort, out_ready;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;

  logic          in_ready, enc1, enc2, enc3, enc4, out_valid, busy;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [15:0]   frame_cnt;

  logic          in_ready_b, enc1_b, enc2_b, enc3_b, enc4_b, out_valid_b, busy_b;
  logic [XW-1:0] x_out_b;
  logic [YW-1:0] y_out_b;
  logic [15:0]   frame_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state.
  logic          m_busy, m_done;
  int            m_k;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [15:0]   m_cnt;
  logic          chk_b = 1'b0;
  int            rise_k;

  always #5 clk = ~clk;

  infer_sched dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .x_out(x_out), .enc1_start(enc1), .enc2_start(enc2), .enc3_start(enc3),
    .enc4_start(enc4), .abort(abort), .y_in(y_in), .out_valid(out_valid),
    .out_ready(out_ready), .y_out(y_out), .busy(busy), .frame_cnt(frame_cnt)
  );

  infer_sched #(.L1_LAT(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .x_in(x_in),
    .x_out(x_out_b), .enc1_start(enc1_b), .enc2_start(enc2_b), .enc3_start(enc3_b),
    .enc4_start(enc4_b), .abort(abort), .y_in(y_in), .out_valid(out_valid_b),
    .out_ready(out_ready), .y_out(y_out_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (m_k=%0d)", tag, obs, exp, m_k);
    end
  endtask

  function automatic logic [XW-1:0] rx();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] ry();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[YW-1:0];
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare outputs.
  task automatic step();
    logic run;
    @(posedge clk);
    if (!reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_k = 0; m_x = '0; m_y = '0; m_cnt = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1; m_done = 1'b0; m_k = 0; m_x = x_in;
      end
    end else if (m_done) begin
      if (out_ready) begin
        m_busy = 1'b0; m_done = 1'b0; m_cnt = m_cnt + 16'd1;
      end
    end else if (abort) begin
      m_busy = 1'b0;
    end else begin
      m_k++;
      if (m_k == ODN) begin
        m_done = 1'b1; m_y = y_in;
      end
    end
    #1;
    run = m_busy && !m_done;
    chk("in_ready", 256'(in_ready), 256'(!m_busy));
    chk("busy", 256'(busy), 256'(m_busy));
    chk("enc1_start", 256'(enc1), 256'(run && m_k == 0));
    chk("enc2_start", 256'(enc2), 256'(run && m_k == O2));
    chk("enc3_start", 256'(enc3), 256'(run && m_k == O3));
    chk("enc4_start", 256'(enc4), 256'(run && m_k == O4));
    chk("out_valid", 256'(out_valid), 256'(m_done));
    chk("x_out", 256'(x_out), 256'(m_x));
    chk("y_out", 256'(y_out), 256'(m_y));
    chk("frame_cnt", 256'(frame_cnt), 256'(m_cnt));
    if (chk_b) begin
      // L1_LAT=0 instance: L1 lasts one cycle, so every later boundary moves up by 3.
      chk("b_enc1_start", 256'(enc1_b), 256'(m_k == 0));
      chk("b_enc2_start", 256'(enc2_b), 256'(m_k == 1));
      chk("b_enc3_start", 256'(enc3_b), 256'(m_k == O3 - 3));
      chk("b_out_valid", 256'(out_valid_b), 256'(m_k >= ODN - 3));
    end
    if (out_valid && rise_k < 0) rise_k = m_k;
  endtask

  task automatic quiet();
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; quiet(); x_in = rx(); y_in = ry();
    m_busy = 1'b0; m_done = 1'b0; m_k = 0; m_x = '0; m_y = '0; m_cnt = '0;
    rise_k = -1;

    // Reset state.
    step(); step();
    reset = 1'b1;
    step();

    // Frame 1: full schedule, in_valid held while busy, x_in toggling.
    in_valid = 1'b1; x_in = rx();
    step();
    chk_b = 1'b1;
    for (int i = 0; i < ODN; i++) begin
      x_in = rx(); y_in = ry();
      step();
    end
    chk_b = 1'b0;
    chk("out_valid_rise_cycle", 256'(rise_k), 256'(27));
    // Stall in DONE with in_valid high.
    for (int i = 0; i < 10; i++) begin
      x_in = rx(); y_in = ry();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b1; x_in = rx();
    step();
    in_valid = 1'b0;

    // Frame 2: abort during the lambda stage.
    for (int i = 0; i < 10; i++) begin y_in = ry(); step(); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 30; i++) step();

    // Frame 3: reset mid-frame.
    in_valid = 1'b1; x_in = rx();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) step();

    // Frame 4: abort ignored in DONE when out_ready is also high, and in IDLE.
    in_valid = 1'b1; x_in = rx();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < ODN + 2; i++) begin y_in = ry(); step(); end
    abort = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step(); step();
    abort = 1'b0;

    // Frame 5: counter wrap from a preloaded 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    in_valid = 1'b1; x_in = rx();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < ODN; i++) begin y_in = ry(); step(); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("frame_cnt_wrap", 256'(frame_cnt), 256'(0));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom % 2);
      abort     = ($urandom % 40) == 0;
      out_ready = ($urandom % 3) == 0;
      reset     = !(($urandom % 300) == 0);
      x_in = rx(); y_in = ry();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/infer_sched.md
INFER_SCHED -- requirements
Module: infer_sched

Interface
REQ-001 Parameter BITSIZE, 24, fixed-point word width.
REQ-002 Parameter L1_LAT, 4, cycles allotted to enc_1 plus softplus plus register.
REQ-003 Parameter L2_LAT, 4, cycles allotted to enc_2 (mean/var).
REQ-004 Parameter LAM_LAT, 6, cycles allotted to the lambda layer.
REQ-005 Parameter L3_LAT, 4, cycles allotted to enc_3 plus softplus plus register.
REQ-006 Parameter L4_LAT, 4, cycles allotted to enc_4.
REQ-007 Parameter ACT_LAT, 5, cycles allotted to the output sigmoid.
REQ-008 Port clk, in, 1, single clock; all logic on rising edge.
REQ-009 Port reset, in, 1, synchronous, active-low.
REQ-010 Port in_valid, in, 1, input frame offered.
REQ-011 Port in_ready, out, 1, scheduler can accept a frame.
REQ-012 Port x_in, in, BITSIZE*10, input feature vector.
REQ-013 Port x_out, out, BITSIZE*10, latched feature vector driven to the datapath.
REQ-014 Port enc1_start, enc2_start, enc3_start, enc4_start, out, 1 each, one-cycle layer start pulses.
REQ-015 Port abort, in, 1, cancel the frame in flight.
REQ-016 Port y_in, in, BITSIZE*2, sigmoid outputs from the datapath.
REQ-017 Port out_valid, out, 1, result available.
REQ-018 Port out_ready, in, 1, consumer accepts the result.
REQ-019 Port y_out, out, BITSIZE*2, captured result.
REQ-020 Port busy, out, 1, high in any state other than IDLE.
REQ-021 Port frame_cnt, out, 16, number of completed frames.

Function
REQ-022 The FSM SHALL have exactly these states: IDLE, S_L1, S_L2, S_LAM, S_L3, S_L4, S_ACT, DONE.
REQ-023 in_ready SHALL be high only in IDLE.
REQ-024 Accept: an edge with in_valid=1 and in_ready=1 SHALL latch x_in into x_out and move the FSM to S_L1.
REQ-025 x_out SHALL hold its value until the next accept.
REQ-026 Each stage S_L1 through S_ACT SHALL last exactly its *_LAT cycles, timed by an 8-bit down-counter that is loaded on stage entry.
REQ-027 Stages SHALL advance in the order L1, L2, LAM, L3, L4, ACT, DONE.
REQ-028 enc1_start, enc2_start, enc3_start and enc4_start SHALL each be high only in the first cycle of S_L1, S_L2, S_L3 and S_L4 respectively.
REQ-029 The start pulses SHALL be registered outputs; S_LAM and S_ACT assert no pulse.
REQ-030 On the S_ACT-to-DONE edge, y_in SHALL be captured into y_out and out_valid SHALL be set.
REQ-031 With default parameters, out_valid SHALL rise 27 cycles after the accept edge.
REQ-032 In DONE, out_valid and y_out SHALL hold stable until out_ready=1.
REQ-033 On the completing edge, out_valid SHALL clear, the FSM SHALL return to IDLE, and frame_cnt SHALL increment.
REQ-034 frame_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-035 in_ready SHALL return high the cycle after DONE completes; no frame is accepted in the same cycle as completion.
REQ-036 abort=1 in any state other than IDLE or DONE SHALL force IDLE on the next edge.
REQ-037 An aborted frame SHALL NOT assert out_valid, SHALL NOT increment frame_cnt, and SHALL suppress any start pulse due on that edge.
REQ-038 abort SHALL be ignored in IDLE and in DONE.
REQ-039 If abort and out_ready are both high in DONE, the frame SHALL complete normally.
REQ-040 A *_LAT value of 0 SHALL be treated as 1.
REQ-041 in_valid while the FSM is busy SHALL have no effect.
REQ-042 x_in SHALL NOT be sampled except on an accept edge.

Reset
REQ-043 reset=0 at a rising edge SHALL force state IDLE, all counters to 0, x_out and y_out to 0, frame_cnt to 0, and all start pulses, out_valid and busy to 0.
REQ-044 With reset=0, in_ready SHALL be 1 immediately after the reset edge.
REQ-045 reset=0 mid-frame SHALL discard the frame with no out_valid and no start pulse after the reset edge.

Verification
REQ-046 Single frame, defaults, accept at edge t -> enc1_start at t+0, enc2_start at t+4, enc3_start at t+14, enc4_start at t+18, out_valid at t+27, y_out equal to y_in sampled at t+27, frame_cnt=1.
REQ-047 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_valid and y_out stay stable, in_ready=0, no accept; out_ready=1 -> IDLE, then the next frame is accepted.
REQ-048 abort at t+10 (during S_LAM) -> IDLE at t+11, no enc3_start or enc4_start, no out_valid, frame_cnt unchanged.
REQ-049 reset=0 at t+16 -> all outputs 0 and in_ready=1 on the next cycle; no further start pulses.
REQ-050 Preload 65535 completed frames (force or run) and complete one more -> frame_cnt=0x0000.
REQ-051 L1_LAT=0 with other parameters at default -> S_L1 lasts 1 cycle and enc2_start occurs at t+1.
